// File: rtl/alu_uart_pkg.sv
// Shared types and constants for the UART <-> ALU
// command sequencer.
package alu_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_B,
    ST_WAIT_OP,
    ST_EXEC,
    ST_SEND_RES,
    ST_WAIT_TX_RES,
    ST_SEND_FLG,
    ST_WAIT_TX_FLG
  } state_t;

  localparam int FLAG_NEG   = 0;
  localparam int FLAG_ZERO  = 1;
  localparam int FLAG_CARRY = 2;

  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
  localparam logic [5:0] OP_AND = 6'h24;
  localparam logic [5:0] OP_OR  = 6'h25;
  localparam logic [5:0] OP_XOR = 6'h26;
  localparam logic [5:0] OP_NOR = 6'h27;
  localparam logic [5:0] OP_SRL = 6'h02;
  localparam logic [5:0] OP_SRA = 6'h03;

endpackage

// File: rtl/alu_uart_if.sv
// UART rx/tx handshakes and ALU operand/result bus
// seen by the sequencer (master) and its peers (slave).
interface alu_uart_if #(
  parameter int DATA_WIDTH = 8,
  parameter int OP_WIDTH   = 6
);

  logic [7:0]            i_rx_data;
  logic                  i_rx_done;
  logic [DATA_WIDTH-1:0] o_alu_a;
  logic [DATA_WIDTH-1:0] o_alu_b;
  logic [OP_WIDTH-1:0]   o_alu_op;
  logic [DATA_WIDTH-1:0] i_alu_result;
  logic                  i_alu_negative;
  logic                  i_alu_zero;
  logic                  i_alu_carry;
  logic [7:0]            o_tx_data;
  logic                  o_tx_start;
  logic                  i_tx_done;
  logic                  o_busy;
  logic                  o_frame_error;
  logic                  o_rx_dropped;

  modport master (
    input  i_rx_data, i_rx_done,
    input  i_alu_result, i_alu_negative,
    input  i_alu_zero, i_alu_carry,
    input  i_tx_done,
    output o_alu_a, o_alu_b, o_alu_op,
    output o_tx_data, o_tx_start,
    output o_busy, o_frame_error,
    output o_rx_dropped
  );

  modport slave (
    output i_rx_data, i_rx_done,
    output i_alu_result, i_alu_negative,
    output i_alu_zero, i_alu_carry,
    output i_tx_done,
    input  o_alu_a, o_alu_b, o_alu_op,
    input  o_tx_data, o_tx_start,
    input  o_busy, o_frame_error,
    input  o_rx_dropped
  );

endinterface

// File: rtl/alu_uart_ctrl_rx_timeout_counter.sv
// Inter-byte idle counter; expired is high during the
// last allowed idle cycle.
module rx_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);

  logic [W-1:0] count;

  assign expired = (count == W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/alu_uart_ctrl.sv
// Collects A/B/opcode bytes, runs the ALU and returns
// result and flag bytes over the UART tx handshake.
module alu_uart_ctrl
  import alu_uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int OP_WIDTH       = 6,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  alu_uart_if.master  bus
);

  state_t                state;
  logic [DATA_WIDTH-1:0] flag_q;
  logic [DATA_WIDTH-1:0] flag_byte;
  logic                  in_wait;
  logic                  in_tx;
  logic                  expired;

  assign in_wait = (state == ST_WAIT_B) ||
                   (state == ST_WAIT_OP);
  assign in_tx   = !in_wait && (state != ST_IDLE);

  always_comb begin
    flag_byte             = '0;
    flag_byte[FLAG_NEG]   = bus.i_alu_negative;
    flag_byte[FLAG_ZERO]  = bus.i_alu_zero;
    flag_byte[FLAG_CARRY] = bus.i_alu_carry;
  end

  rx_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (i_clk),
    .rst     (i_reset),
    .clear   (!in_wait || bus.i_rx_done),
    .enable  (in_wait),
    .expired (expired)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state             <= ST_IDLE;
      flag_q            <= '0;
      bus.o_alu_a       <= '0;
      bus.o_alu_b       <= '0;
      bus.o_alu_op      <= '0;
      bus.o_tx_data     <= '0;
      bus.o_tx_start    <= 1'b0;
      bus.o_busy        <= 1'b0;
      bus.o_frame_error <= 1'b0;
      bus.o_rx_dropped  <= 1'b0;
    end else begin
      bus.o_tx_start    <= 1'b0;
      bus.o_frame_error <= 1'b0;
      bus.o_rx_dropped  <= in_tx && bus.i_rx_done;
      unique case (state)
        ST_IDLE: begin
          if (bus.i_rx_done) begin
            bus.o_alu_a <= bus.i_rx_data;
            bus.o_busy  <= 1'b1;
            state       <= ST_WAIT_B;
          end
        end
        ST_WAIT_B: begin
          if (bus.i_rx_done) begin
            bus.o_alu_b <= bus.i_rx_data;
            state       <= ST_WAIT_OP;
          end else if (expired) begin
            bus.o_busy        <= 1'b0;
            bus.o_frame_error <= 1'b1;
            state             <= ST_IDLE;
          end
        end
        ST_WAIT_OP: begin
          if (bus.i_rx_done) begin
            bus.o_alu_op <= bus.i_rx_data[OP_WIDTH-1:0];
            state        <= ST_EXEC;
          end else if (expired) begin
            bus.o_busy        <= 1'b0;
            bus.o_frame_error <= 1'b1;
            state             <= ST_IDLE;
          end
        end
        // start is raised on exit so it is high in SEND_RES
        ST_EXEC: begin
          bus.o_tx_data  <= bus.i_alu_result;
          bus.o_tx_start <= 1'b1;
          flag_q         <= flag_byte;
          state          <= ST_SEND_RES;
        end
        ST_SEND_RES: begin
          state <= ST_WAIT_TX_RES;
        end
        ST_WAIT_TX_RES: begin
          if (bus.i_tx_done) begin
            state <= ST_SEND_FLG;
          end
        end
        ST_SEND_FLG: begin
          bus.o_tx_data  <= flag_q;
          bus.o_tx_start <= 1'b1;
          state          <= ST_WAIT_TX_FLG;
        end
        ST_WAIT_TX_FLG: begin
          if (bus.i_tx_done) begin
            bus.o_busy <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: begin
          bus.o_busy <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Directed bench for alu_uart_ctrl with a behavioural
// ALU model and a short inter-byte timeout.
module tb_alu_uart_ctrl;
  import alu_uart_pkg::*;

  localparam int T = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_bad = 0;

  alu_uart_if #(.DATA_WIDTH(8), .OP_WIDTH(6)) bus ();

  alu_uart_ctrl #(
    .DATA_WIDTH(8),
    .OP_WIDTH(6),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  logic [8:0] alu_s;
  logic [7:0] alu_r;
  logic       alu_c;

  always_comb begin
    alu_s = '0;
    alu_r = '0;
    alu_c = 1'b0;
    case (bus.o_alu_op)
      OP_ADD: begin
        alu_s = {1'b0, bus.o_alu_a} + {1'b0, bus.o_alu_b};
        alu_r = alu_s[7:0];
        alu_c = alu_s[8];
      end
      OP_SUB: begin
        alu_s = {1'b0, bus.o_alu_a} - {1'b0, bus.o_alu_b};
        alu_r = alu_s[7:0];
        alu_c = ~alu_s[8];
      end
      OP_AND: alu_r = bus.o_alu_a & bus.o_alu_b;
      OP_OR:  alu_r = bus.o_alu_a | bus.o_alu_b;
      OP_XOR: alu_r = bus.o_alu_a ^ bus.o_alu_b;
      OP_NOR: alu_r = ~(bus.o_alu_a | bus.o_alu_b);
      OP_SRL: alu_r = bus.o_alu_a >> bus.o_alu_b[2:0];
      OP_SRA: alu_r = 8'($signed(bus.o_alu_a) >>> bus.o_alu_b[2:0]);
      default: alu_r = '0;
    endcase
    bus.i_alu_result   = alu_r;
    bus.i_alu_negative = alu_r[7];
    bus.i_alu_zero     = (alu_r == 8'h00);
    bus.i_alu_carry    = alu_c;
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] op;
    logic [7:0] res;
    logic [7:0] flg;
  } vec_t;

  vec_t vecs [11];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    bus.i_rx_data = d;
    bus.i_rx_done = 1'b1;
    step();
    bus.i_rx_done = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a,
                            input logic [7:0] b,
                            input logic [7:0] op);
    send_byte(a);
    send_byte(b);
    send_byte(op);
    chk("alu_a", bus.o_alu_a, a);
    chk("alu_b", bus.o_alu_b, b);
    chk("alu_op", bus.o_alu_op, op[5:0]);
  endtask

  // entered during the EXEC cycle
  task automatic finish_tx(input logic [7:0] res,
                           input logic [7:0] flg,
                           input bit drop);
    chk("exec_no_start", bus.o_tx_start, 0);
    step();
    chk("res_start", bus.o_tx_start, 1);
    chk("res_data", bus.o_tx_data, res);
    step();
    chk("res_pulse", bus.o_tx_start, 0);
    if (drop) begin
      bus.i_rx_data = 8'hAA;
      bus.i_rx_done = 1'b1;
      step();
      bus.i_rx_done = 1'b0;
      chk("dropped", bus.o_rx_dropped, 1);
      chk("drop_busy", bus.o_busy, 1);
      step();
      chk("drop_pulse", bus.o_rx_dropped, 0);
      chk("drop_start", bus.o_tx_start, 0);
    end else begin
      step();
    end
    chk("res_hold", bus.o_tx_data, res);
    bus.i_tx_done = 1'b1;
    step();
    bus.i_tx_done = 1'b0;
    chk("flg_gap", bus.o_tx_start, 0);
    step();
    chk("flg_start", bus.o_tx_start, 1);
    chk("flg_data", bus.o_tx_data, flg);
    step();
    step();
    chk("flg_hold", bus.o_tx_data, flg);
    bus.i_tx_done = 1'b1;
    step();
    bus.i_tx_done = 1'b0;
    chk("done_idle", bus.o_busy, 0);
  endtask

  task automatic chk_zero(input string name);
    chk(name, {bus.o_alu_a, bus.o_alu_b, bus.o_alu_op,
               bus.o_tx_data, bus.o_tx_start, bus.o_busy,
               bus.o_frame_error, bus.o_rx_dropped}, 0);
  endtask

  initial begin
    int fe;
    int st;
    vecs[0]  = '{8'h05, 8'h03, 8'h20, 8'h08, 8'h00};
    vecs[1]  = '{8'h03, 8'h05, 8'h22, 8'hFE, 8'h01};
    vecs[2]  = '{8'hF0, 8'h0F, 8'h24, 8'h00, 8'h02};
    vecs[3]  = '{8'hFF, 8'h01, 8'h20, 8'h00, 8'h06};
    vecs[4]  = '{8'h0F, 8'hF0, 8'h25, 8'hFF, 8'h01};
    vecs[5]  = '{8'hFF, 8'h0F, 8'h26, 8'hF0, 8'h01};
    vecs[6]  = '{8'h00, 8'h00, 8'h27, 8'hFF, 8'h01};
    vecs[7]  = '{8'h80, 8'h03, 8'h02, 8'h10, 8'h00};
    vecs[8]  = '{8'h80, 8'h01, 8'h03, 8'hC0, 8'h01};
    vecs[9]  = '{8'h05, 8'h05, 8'h22, 8'h00, 8'h06};
    vecs[10] = '{8'h05, 8'h03, 8'hFF, 8'h00, 8'h02};

    bus.i_rx_data = '0;
    bus.i_rx_done = 1'b0;
    bus.i_tx_done = 1'b0;
    step();
    step();
    chk_zero("reset_outs");
    rst = 1'b0;
    step();
    chk_zero("post_reset");

    bus.i_tx_done = 1'b1;
    step();
    bus.i_tx_done = 1'b0;
    chk("idle_txdone_busy", bus.o_busy, 0);
    chk("idle_txdone_start", bus.o_tx_start, 0);

    for (int i = 0; i < 11; i++) begin
      send_frame(vecs[i].a, vecs[i].b, vecs[i].op);
      finish_tx(vecs[i].res, vecs[i].flg, 1'b0);
      step();
    end

    // timeout after operand A
    send_byte(8'h05);
    fe = 0;
    for (int i = 0; i < T - 1; i++) begin
      step();
      fe += int'(bus.o_frame_error);
    end
    chk("to_early", fe, 0);
    chk("to_busy_before", bus.o_busy, 1);
    step();
    chk("to_error", bus.o_frame_error, 1);
    chk("to_busy", bus.o_busy, 0);
    chk("to_keep_a", bus.o_alu_a, 8'h05);
    step();
    chk("to_pulse", bus.o_frame_error, 0);
    send_frame(8'h01, 8'h01, 8'h20);
    finish_tx(8'h02, 8'h00, 1'b0);
    step();

    // byte arriving on the expiry cycle is accepted
    send_byte(8'h05);
    for (int i = 0; i < T - 1; i++) step();
    send_byte(8'h07);
    chk("edge_no_error", bus.o_frame_error, 0);
    chk("edge_busy", bus.o_busy, 1);
    chk("edge_b", bus.o_alu_b, 8'h07);
    send_byte(8'h20);
    chk("edge_op", bus.o_alu_op, 6'h20);
    finish_tx(8'h0C, 8'h00, 1'b0);
    step();

    // stray rx byte during transmit
    send_frame(8'h10, 8'h20, 8'h20);
    finish_tx(8'h30, 8'h00, 1'b1);
    step();
    send_frame(8'h03, 8'h05, 8'h22);
    finish_tx(8'hFE, 8'h01, 1'b0);
    step();

    // reset in WAIT_OP
    send_byte(8'h11);
    send_byte(8'h22);
    #2 rst = 1'b1;
    #1 chk_zero("rst_wait_op");
    @(posedge clk);
    #1 rst = 1'b0;
    st = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      st += int'(bus.o_tx_start);
    end
    chk("rst_op_no_start", st, 0);
    chk("rst_op_idle", bus.o_busy, 0);

    // reset in WAIT_TX_FLG
    send_frame(8'h05, 8'h03, 8'h20);
    step();
    chk("r2_res_start", bus.o_tx_start, 1);
    step();
    bus.i_tx_done = 1'b1;
    step();
    bus.i_tx_done = 1'b0;
    step();
    chk("r2_flg_start", bus.o_tx_start, 1);
    step();
    #2 rst = 1'b1;
    #1 chk_zero("rst_wait_tx_flg");
    @(posedge clk);
    #1 rst = 1'b0;
    st = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      st += int'(bus.o_tx_start);
    end
    chk("rst_flg_no_start", st, 0);
    chk("rst_flg_idle", bus.o_busy, 0);

    send_frame(8'hFF, 8'h01, 8'h20);
    finish_tx(8'h00, 8'h06, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_chk, n_bad);
    $finish;
  end

endmodule
